// File: rtl/mips_control_signal_register_pipeline_if.sv
// Bus between the ID stage / datapath and the control-signal register pipeline.
// The slave side is the pipeline and the master side is the decoder/datapath driving it.
// Carries decoded ID fields, datapath data and the resulting stall, forward and write-back controls.
interface mips_control_signal_register_pipeline_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              idValid;
  logic              idPort1AddrSource;
  logic [1:0]        idWriteAddrSource;
  logic              idWriteDataSource;
  logic              idWriteEnable;
  logic [ADDR_W-1:0] idRs;
  logic [ADDR_W-1:0] idRt;
  logic [ADDR_W-1:0] idRd;
  logic              flush;
  logic [DATA_W-1:0] exAluResult;
  logic [DATA_W-1:0] memLoadData;
  logic              stall;
  logic [1:0]        fwd1Select;
  logic [1:0]        fwd2Select;
  logic              wbWriteEnable;
  logic [ADDR_W-1:0] wbWriteAddr;
  logic [DATA_W-1:0] wbWriteData;

  modport slave (
    input  idValid, idPort1AddrSource, idWriteAddrSource, idWriteDataSource, idWriteEnable,
    input  idRs, idRt, idRd, flush, exAluResult, memLoadData,
    output stall, fwd1Select, fwd2Select, wbWriteEnable, wbWriteAddr, wbWriteData
  );

  modport master (
    output idValid, idPort1AddrSource, idWriteAddrSource, idWriteDataSource, idWriteEnable,
    output idRs, idRt, idRd, flush, exAluResult, memLoadData,
    input  stall, fwd1Select, fwd2Select, wbWriteEnable, wbWriteAddr, wbWriteData
  );
endinterface

// File: rtl/mips_control_signal_register_pipeline.sv
// Carries register-write control through EX/MEM/WB, detecting load-use hazards and selecting forwards.
// Latency: an instruction accepted in ID at cycle n drives the write-back port in cycle n+3.
// Backpressure: stall inserts one bubble into EX; EX, MEM and WB keep advancing every cycle.
module mips_control_signal_register_pipeline #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic clock,
  input  logic resetN,
  mips_control_signal_register_pipeline_if.slave bus
);

  // ID-side resolved fields
  logic [ADDR_W-1:0] id_src1;
  logic [ADDR_W-1:0] id_waddr;
  logic              id_we;
  logic              stall;

  // EX stage
  logic              ex_valid;
  logic [ADDR_W-1:0] ex_waddr;
  logic              ex_wds;
  logic              ex_we;
  logic [ADDR_W-1:0] ex_src1;
  logic [ADDR_W-1:0] ex_src2;

  // MEM stage
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_waddr;
  logic              mem_wds;
  logic              mem_we;
  logic [DATA_W-1:0] mem_data;

  // WB stage
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_waddr;
  logic              wb_we;
  logic [DATA_W-1:0] wb_data;

  logic [1:0] fwd1;
  logic [1:0] fwd2;

  // Resolve operand/destination addresses; a write to r0 is dropped here so no later stage sees it.
  always_comb begin
    id_src1 = bus.idPort1AddrSource ? bus.idRt : bus.idRs;
    case (bus.idWriteAddrSource)
      2'd1:    id_waddr = bus.idRd;
      2'd2:    id_waddr = ADDR_W'(31);
      default: id_waddr = bus.idRt;
    endcase
    id_we = bus.idWriteEnable && (id_waddr != '0);
  end

  // Load-use hazard: a load in EX has no data yet for an ID instruction reading its destination.
  always_comb begin
    stall = bus.idValid && ex_valid && ex_we && ex_wds &&
            ((ex_waddr == id_src1) || (ex_waddr == bus.idRt));
  end

  // ID->EX: capture the ID instruction, or a bubble on stall/flush (both together are one bubble).
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      ex_valid <= 1'b0;
      ex_waddr <= '0;
      ex_wds   <= 1'b0;
      ex_we    <= 1'b0;
      ex_src1  <= '0;
      ex_src2  <= '0;
    end else if (stall || bus.flush) begin
      ex_valid <= 1'b0;
      ex_waddr <= '0;
      ex_wds   <= 1'b0;
      ex_we    <= 1'b0;
      ex_src1  <= '0;
      ex_src2  <= '0;
    end else begin
      ex_valid <= bus.idValid;
      ex_waddr <= id_waddr;
      ex_wds   <= bus.idWriteDataSource;
      ex_we    <= id_we;
      ex_src1  <= id_src1;
      ex_src2  <= bus.idRt;
    end
  end

  // EX->MEM and MEM->WB advance unconditionally; WB data picks load data for loads, ALU data otherwise.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      mem_valid <= 1'b0;
      mem_waddr <= '0;
      mem_wds   <= 1'b0;
      mem_we    <= 1'b0;
      mem_data  <= '0;
      wb_valid  <= 1'b0;
      wb_waddr  <= '0;
      wb_we     <= 1'b0;
      wb_data   <= '0;
    end else begin
      mem_valid <= ex_valid;
      mem_waddr <= ex_waddr;
      mem_wds   <= ex_wds;
      mem_we    <= ex_we;
      mem_data  <= bus.exAluResult;
      wb_valid  <= mem_valid;
      wb_waddr  <= mem_waddr;
      wb_we     <= mem_we;
      wb_data   <= mem_wds ? bus.memLoadData : mem_data;
    end
  end

  // Forward selection for the EX operands; the younger MEM result wins over WB, and a MEM load cannot forward.
  always_comb begin
    fwd1 = 2'd0;
    fwd2 = 2'd0;
    if (ex_valid) begin
      if (mem_valid && mem_we && !mem_wds && (mem_waddr == ex_src1)) begin
        fwd1 = 2'd1;
      end else if (wb_valid && wb_we && (wb_waddr == ex_src1)) begin
        fwd1 = 2'd2;
      end
      if (mem_valid && mem_we && !mem_wds && (mem_waddr == ex_src2)) begin
        fwd2 = 2'd1;
      end else if (wb_valid && wb_we && (wb_waddr == ex_src2)) begin
        fwd2 = 2'd2;
      end
    end
  end

  assign bus.stall         = stall;
  assign bus.fwd1Select    = fwd1;
  assign bus.fwd2Select    = fwd2;
  assign bus.wbWriteEnable = wb_valid && wb_we;
  assign bus.wbWriteAddr   = wb_waddr;
  assign bus.wbWriteData   = wb_data;

endmodule

// File: tb/tb_mips_control_signal_register_pipeline.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based instruction model.
// Inputs change on the falling edge; outputs are checked 1 time unit later, well before the rising edge.
module tb_mips_control_signal_register_pipeline;

  logic clock = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  mips_control_signal_register_pipeline_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  mips_control_signal_register_pipeline #(.ADDR_W(5), .DATA_W(32)) dut (
    .clock (clock),
    .resetN(resetN),
    .bus   (bus)
  );

  // One in-flight instruction as seen by the model; pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB.
  typedef struct {
    bit        valid;
    bit        writes;
    bit        load;
    bit [4:0]  dest;
    bit [4:0]  s1;
    bit [4:0]  s2;
    bit [31:0] data;
  } rec_t;

  rec_t pipe[$];
  rec_t nxt;
  bit   exp_stall;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic rec_t bubble();
    rec_t r;
    r = '{default: 0};
    return r;
  endfunction

  task automatic clear_model();
    pipe.delete();
    for (int i = 0; i < 3; i++) pipe.push_back(bubble());
  endtask

  function automatic int exp_fwd(bit [4:0] src);
    if (!pipe[0].valid) return 0;
    if (pipe[1].valid && pipe[1].writes && !pipe[1].load && pipe[1].dest == src) return 1;
    if (pipe[2].valid && pipe[2].writes && pipe[2].dest == src) return 2;
    return 0;
  endfunction

  task automatic set_id(input bit v, input bit p1, input bit [1:0] ws, input bit wds, input bit we,
                        input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd);
    bus.idValid = v;
    bus.idPort1AddrSource = p1;
    bus.idWriteAddrSource = ws;
    bus.idWriteDataSource = wds;
    bus.idWriteEnable = we;
    bus.idRs = rs;
    bus.idRt = rt;
    bus.idRd = rd;
    bus.flush = 1'b0;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Check all outputs against the model for the current cycle and work out what EX captures next.
  task automatic settle();
    bit [4:0] id_s1;
    bit [4:0] id_dest;
    #1;
    pipe[0].data = bus.exAluResult;
    if (pipe[1].load) pipe[1].data = bus.memLoadData;
    id_s1 = bus.idPort1AddrSource ? bus.idRt : bus.idRs;
    case (bus.idWriteAddrSource)
      2'd1:    id_dest = bus.idRd;
      2'd2:    id_dest = 5'd31;
      default: id_dest = bus.idRt;
    endcase
    exp_stall = bus.idValid && pipe[0].valid && pipe[0].writes && pipe[0].load &&
                (pipe[0].dest == id_s1 || pipe[0].dest == bus.idRt);
    check_val("stall", bus.stall, exp_stall);
    check_val("fwd1", bus.fwd1Select, exp_fwd(pipe[0].s1));
    check_val("fwd2", bus.fwd2Select, exp_fwd(pipe[0].s2));
    check_val("wb_we", bus.wbWriteEnable, pipe[2].valid && pipe[2].writes);
    if (pipe[2].valid && pipe[2].writes) begin
      check_val("wb_addr", bus.wbWriteAddr, pipe[2].dest);
      check_val("wb_data", bus.wbWriteData, pipe[2].data);
    end
    if (exp_stall || bus.flush) begin
      nxt = bubble();
    end else begin
      nxt = bubble();
      nxt.valid  = bus.idValid;
      nxt.dest   = id_dest;
      nxt.writes = bus.idWriteEnable && id_dest != 0;
      nxt.load   = bus.idWriteDataSource;
      nxt.s1     = id_s1;
      nxt.s2     = bus.idRt;
    end
  endtask

  task automatic advance();
    @(posedge clock);
    pipe.push_front(nxt);
    void'(pipe.pop_back());
    @(negedge clock);
    bus.exAluResult = $urandom;
    bus.memLoadData = $urandom;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      idle();
      step();
    end
  endtask

  function automatic bit [4:0] rnd_reg();
    return ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    bus.exAluResult = '0;
    bus.memLoadData = '0;
    clear_model();
    @(negedge clock);
    @(negedge clock);
    check_val("rst_stall", bus.stall, 0);
    check_val("rst_fwd1", bus.fwd1Select, 0);
    check_val("rst_fwd2", bus.fwd2Select, 0);
    check_val("rst_we", bus.wbWriteEnable, 0);
    check_val("rst_addr", bus.wbWriteAddr, 0);
    check_val("rst_data", bus.wbWriteData, 0);
    resetN = 1'b1;

    // ALU op writing r5
    set_id(1, 0, 1, 0, 1, 0, 0, 5); step();
    idle(); bus.exAluResult = 32'h1234; step();
    idle(); step();
    idle(); settle();
    check_val("alu_we", bus.wbWriteEnable, 1);
    check_val("alu_addr", bus.wbWriteAddr, 5);
    check_val("alu_data", bus.wbWriteData, 32'h1234);
    advance();

    // Back-to-back dependency -> MEM forward
    set_id(1, 0, 1, 0, 1, 0, 0, 5); step();
    set_id(1, 0, 0, 0, 0, 5, 0, 0); step();
    idle(); settle();
    check_val("b2b_fwd1", bus.fwd1Select, 1);
    advance();
    drain();

    // One bubble between -> WB forward
    set_id(1, 0, 1, 0, 1, 0, 0, 5); step();
    idle(); step();
    set_id(1, 0, 0, 0, 0, 5, 0, 0); step();
    idle(); settle();
    check_val("gap_fwd1", bus.fwd1Select, 2);
    advance();
    drain();

    // Load-use on r7
    set_id(1, 0, 0, 1, 1, 0, 7, 0); step();
    set_id(1, 0, 0, 0, 0, 1, 7, 0); settle();
    check_val("lu_stall1", bus.stall, 1);
    advance();
    set_id(1, 0, 0, 0, 0, 1, 7, 0); bus.memLoadData = 32'hCAFE; settle();
    check_val("lu_stall2", bus.stall, 0);
    advance();
    idle(); settle();
    check_val("lu_fwd2", bus.fwd2Select, 2);
    check_val("lu_data", bus.wbWriteData, 32'hCAFE);
    check_val("lu_addr", bus.wbWriteAddr, 7);
    advance();
    drain();

    // Write to r0, then a reader of r0
    set_id(1, 0, 0, 0, 1, 0, 0, 0); step();
    set_id(1, 0, 0, 0, 0, 0, 3, 0); step();
    idle(); settle();
    check_val("r0_fwd1", bus.fwd1Select, 0);
    advance();
    idle(); settle();
    check_val("r0_we", bus.wbWriteEnable, 0);
    advance();
    drain();

    // Link to r31, flushed and then not flushed
    set_id(1, 0, 2, 0, 1, 0, 0, 0); bus.flush = 1'b1; step();
    idle(); step();
    idle(); step();
    idle(); settle();
    check_val("lnkf_we", bus.wbWriteEnable, 0);
    advance();
    set_id(1, 0, 2, 0, 1, 0, 0, 0); step();
    idle(); step();
    idle(); step();
    idle(); settle();
    check_val("lnk_we", bus.wbWriteEnable, 1);
    check_val("lnk_addr", bus.wbWriteAddr, 31);
    advance();

    // Reset mid-stream with three writers in flight
    set_id(1, 0, 1, 0, 1, 0, 0, 1); step();
    set_id(1, 0, 1, 0, 1, 0, 0, 2); step();
    set_id(1, 0, 1, 0, 1, 0, 0, 3); step();
    idle();
    #2 resetN = 1'b0;
    #1;
    check_val("arst_we", bus.wbWriteEnable, 0);
    check_val("arst_addr", bus.wbWriteAddr, 0);
    check_val("arst_data", bus.wbWriteData, 0);
    check_val("arst_fwd1", bus.fwd1Select, 0);
    check_val("arst_fwd2", bus.fwd2Select, 0);
    check_val("arst_stall", bus.stall, 0);
    clear_model();
    @(posedge clock);
    @(negedge clock);
    resetN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(); settle();
      check_val("post_rst_we", bus.wbWriteEnable, 0);
      advance();
    end

    // Randomized traffic; a stalled ID instruction is held, as upstream would
    for (int i = 0; i < 600; i++) begin
      if (!exp_stall) begin
        set_id($urandom_range(0, 4) != 0, 1'($urandom), 2'($urandom), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 3) != 0), rnd_reg(), rnd_reg(), rnd_reg());
      end
      bus.flush = ($urandom_range(0, 9) == 0);
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
